// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decode outputs and presents them to the EX stage.
// Latency: 1 cycle from ID inputs to EX outputs; all outputs come straight from flops.
// Backpressure: stall_i holds the stage (with WB refresh of held operands); flush_i inserts a bubble and wins over stall_i.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   stall_i, flush_i        hazard-unit hold / branch-flush bubble insertion
//   valid_i, pc_i, rs*_i,   decode-stage instruction fields
//   imm_i, rd_addr_i,
//   funct_i, ctrl_i
//   wb_we_i, wb_rd_i,       write-back port used for operand bypass and held-operand refresh
//   wb_data_i
//   *_o                     registered copies for EX
//   bubble_cnt_o            saturating count of bubbles loaded into the stage
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [RA_W-1:0]  rs1_addr_i,
  input  logic [RA_W-1:0]  rs2_addr_i,
  input  logic [RA_W-1:0]  rd_addr_i,
  input  logic [9:0]       funct_i,
  input  logic [7:0]       ctrl_i,
  input  logic             wb_we_i,
  input  logic [RA_W-1:0]  wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [RA_W-1:0]  rs1_addr_o,
  output logic [RA_W-1:0]  rs2_addr_o,
  output logic [RA_W-1:0]  rd_addr_o,
  output logic [9:0]       funct_o,
  output logic [7:0]       ctrl_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [9:0]      funct;
    logic [7:0]      ctrl;
  } stage_t;

  stage_t           stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // x0 is hard-wired zero, so a WB to x0 must never be forwarded.
  logic wb_live;
  logic byp_rs1, byp_rs2;   // bypass into a freshly loaded instruction
  logic ref_rs1, ref_rs2;   // refresh of an instruction held by a stall
  logic bubble;

  assign wb_live = wb_we_i && (wb_rd_i != '0);
  assign byp_rs1 = wb_live && (wb_rd_i == rs1_addr_i);
  assign byp_rs2 = wb_live && (wb_rd_i == rs2_addr_i);
  assign ref_rs1 = wb_live && (wb_rd_i == stage_q.rs1_addr);
  assign ref_rs2 = wb_live && (wb_rd_i == stage_q.rs2_addr);

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;

    if (flush_i) begin
      stage_d = '0;
      bubble  = 1'b1;
    end else if (stall_i) begin
      // Without refresh a held instruction would read a register value that
      // WB retires while it waits, and the WB copy is gone next cycle.
      if (stage_q.valid) begin
        if (ref_rs1) stage_d.rs1_data = wb_data_i;
        if (ref_rs2) stage_d.rs2_data = wb_data_i;
      end
    end else begin
      stage_d.valid    = valid_i;
      stage_d.pc       = pc_i;
      stage_d.rs1_data = byp_rs1 ? wb_data_i : rs1_data_i;
      stage_d.rs2_data = byp_rs2 ? wb_data_i : rs2_data_i;
      stage_d.imm      = imm_i;
      stage_d.rs1_addr = rs1_addr_i;
      stage_d.rs2_addr = rs2_addr_i;
      stage_d.rd_addr  = rd_addr_i;
      stage_d.funct    = funct_i;
      // An invalid slot must not carry write enables into later stages.
      stage_d.ctrl     = valid_i ? ctrl_i : 8'h00;
      bubble           = !valid_i;
    end

    if (bubble && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o      = stage_q.valid;
  assign pc_o         = stage_q.pc;
  assign rs1_data_o   = stage_q.rs1_data;
  assign rs2_data_o   = stage_q.rs2_data;
  assign imm_o        = stage_q.imm;
  assign rs1_addr_o   = stage_q.rs1_addr;
  assign rs2_addr_o   = stage_q.rs2_addr;
  assign rd_addr_o    = stage_q.rd_addr;
  assign funct_o      = stage_q.funct;
  assign ctrl_o       = stage_q.ctrl;
  assign bubble_cnt_o = cnt_q;

endmodule
